// File: rtl/axi_timer_cfg_sequencer.sv
// AXI4-Lite master that programs C_NUM_REGS timer registers from a latched config word.
// Define AXI_TIMER_CFG_READBACK_EN to add the read-back/compare phase after the writes.
module axi_timer_cfg_sequencer #(
    parameter int unsigned              C_NUM_REGS   = 4,
    parameter int unsigned              C_ADDR_WIDTH = 4,
    parameter logic [C_ADDR_WIDTH-1:0]  C_BASE_ADDR  = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        start,
    input  logic [32*C_NUM_REGS-1:0]    cfg_data,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [3:0]                  err_idx,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [31:0]                 M_AXI_WDATA,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [31:0]                 M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 idx_q, idx_d;
    logic [32*C_NUM_REGS-1:0]   cfg_q, cfg_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic                       error_q, error_d;
    logic [3:0]                 err_idx_q, err_idx_d;

    logic [31:0]                cur_reg;
    logic [C_ADDR_WIDTH-1:0]    cur_addr;
    logic                       last_reg;

    always_comb begin
        cur_reg = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_reg = cfg_q[32*i +: 32];
            end
        end
    end

    assign cur_addr = C_BASE_ADDR + C_ADDR_WIDTH'({idx_q, 2'b00});
    assign last_reg = (idx_q == 4'(C_NUM_REGS - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cfg_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cfg_q     <= cfg_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cfg_d     = cfg_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d     = cfg_data;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_ADDR_DATA;
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W handshakes may land in different cycles; each side remembers its own.
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_DONE;
                    end else if (last_reg) begin
                        idx_d = '0;
`ifdef AXI_TIMER_CFG_READBACK_EN
                        state_d = S_RD_ADDR;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WR_ADDR_DATA;
                    end
                end
            end
`ifdef AXI_TIMER_CFG_READBACK_EN
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != cur_reg)) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_DONE;
                    end else if (last_reg) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_RD_ADDR;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign error         = error_q;
    assign err_idx       = err_idx_q;

    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWVALID = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
    assign M_AXI_WDATA   = cur_reg;
    assign M_AXI_WVALID  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARADDR  = cur_addr;

`ifdef AXI_TIMER_CFG_READBACK_EN
    assign M_AXI_ARVALID = (state_q == S_RD_ADDR);
    assign M_AXI_RREADY  = (state_q == S_RD_DATA);
`else
    logic unused_rd;
    assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_timer_cfg_sequencer.sv
// Directed bench for axi_timer_cfg_sequencer with a reactive AXI4-Lite slave model.
module tb_axi_timer_cfg_sequencer;

    logic          ACLK;
    logic          ARESETN;
    logic          start;
    logic [127:0]  cfg_data;
    logic          busy, done, error;
    logic [3:0]    err_idx;
    logic [3:0]    M_AXI_AWADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0]   M_AXI_WDATA;
    logic          M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY;
    logic [3:0]    M_AXI_ARADDR;
    logic          M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0]   M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    axi_timer_cfg_sequencer #(
        .C_NUM_REGS   (4),
        .C_ADDR_WIDTH (4),
        .C_BASE_ADDR  (4'h0)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .cfg_data      (cfg_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_idx       (err_idx),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

`ifdef AXI_TIMER_CFG_READBACK_EN
    localparam int RD_CYC = 8;
    localparam int NUM_RD = 4;
`else
    localparam int RD_CYC = 0;
    localparam int NUM_RD = 0;
`endif

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- slave model ----------------
    logic [31:0] mem [4];
    logic [3:0]  aw_hist [256];
    logic [3:0]  ar_hist [256];
    logic [7:0]  aw_count = '0;
    logic [7:0]  ar_count = '0;
    int          aw_delay;
    int          aw_cnt;
    logic        got_aw, got_w;
    logic [3:0]  aw_addr_q;
    logic [31:0] wdata_q;
    logic        err_en, rd_cor_en;
    logic [3:0]  err_addr, rd_cor_addr;
    logic        aw_f, w_f;
    logic [3:0]  wr_a;
    logic [31:0] wr_d;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign aw_f = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_f  = M_AXI_WVALID && M_AXI_WREADY;
    assign wr_a = aw_f ? M_AXI_AWADDR : aw_addr_q;
    assign wr_d = w_f ? M_AXI_WDATA : wdata_q;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt       <= 0;
            got_aw       <= 1'b0;
            got_w        <= 1'b0;
            aw_addr_q    <= '0;
            wdata_q      <= '0;
            M_AXI_BVALID <= 1'b0;
            M_AXI_BRESP  <= 2'b00;
            M_AXI_RVALID <= 1'b0;
            M_AXI_RDATA  <= '0;
            M_AXI_RRESP  <= 2'b00;
        end else begin
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
            else if (aw_f) aw_cnt <= 0;
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (aw_f) begin
                aw_hist[aw_count] <= M_AXI_AWADDR;
                aw_count <= aw_count + 8'd1;
            end
            if ((got_aw || aw_f) && (got_w || w_f)) begin
                got_aw       <= 1'b0;
                got_w        <= 1'b0;
                M_AXI_BVALID <= 1'b1;
                if (err_en && wr_a == err_addr) begin
                    M_AXI_BRESP <= 2'b10;
                end else begin
                    M_AXI_BRESP     <= 2'b00;
                    mem[wr_a[3:2]]  <= wr_d;
                end
            end else begin
                if (aw_f) begin got_aw <= 1'b1; aw_addr_q <= M_AXI_AWADDR; end
                if (w_f)  begin got_w  <= 1'b1; wdata_q   <= M_AXI_WDATA;  end
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_hist[ar_count] <= M_AXI_ARADDR;
                ar_count     <= ar_count + 8'd1;
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RDATA  <= (rd_cor_en && M_AXI_ARADDR == rd_cor_addr) ? 32'h0000_DEAD
                                                                            : mem[M_AXI_ARADDR[3:2]];
            end
        end
    end

    // ---------------- checking ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          cycles;
    logic        busy_at1, err_at1, busy_at_done, done_after, err_at_done;
    logic [3:0]  erridx_at_done;
    int          awv_cyc, wv_cyc;
    logic        bready_early;
    logic [7:0]  aw_base, ar_base;

    // Caller must be at a falling edge. cycles = edges from the start-sampling edge to done.
    task automatic run_seq(input logic [127:0] cfg, input int extra_start_k);
        cycles       = -1;
        awv_cyc      = 0;
        wv_cyc       = 0;
        bready_early = 1'b0;
        aw_base      = aw_count;
        ar_base      = ar_count;
        cfg_data     = cfg;
        start        = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge ACLK);
            start = (k == extra_start_k);
            if (k == extra_start_k) cfg_data = ~cfg;
            if (k == 1) begin
                busy_at1 = busy;
                err_at1  = error;
            end
            if (M_AXI_AWVALID) awv_cyc++;
            if (M_AXI_WVALID) wv_cyc++;
            if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) bready_early = 1'b1;
            if (done) begin
                cycles         = k - 1;
                busy_at_done   = busy;
                err_at_done    = error;
                erridx_at_done = err_idx;
                break;
            end
        end
        start = 1'b0;
        @(negedge ACLK);
        done_after = done;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN     = 1'b0;
        start       = 1'b0;
        cfg_data    = '0;
        aw_delay    = 0;
        err_en      = 1'b0;
        err_addr    = '0;
        rd_cor_en   = 1'b0;
        rd_cor_addr = '0;
        repeat (3) @(negedge ACLK);

        check("rst_busy",    32'(busy), 0);
        check("rst_done",    32'(done), 0);
        check("rst_error",   32'(error), 0);
        check("rst_err_idx", 32'(err_idx), 0);
        check("rst_awvalid", 32'(M_AXI_AWVALID), 0);
        check("rst_wvalid",  32'(M_AXI_WVALID), 0);
        check("rst_bready",  32'(M_AXI_BREADY), 0);
        check("rst_arvalid", 32'(M_AXI_ARVALID), 0);
        check("rst_rready",  32'(M_AXI_RREADY), 0);

        ARESETN = 1'b1;
        @(negedge ACLK);

        // cfg 1,2,3,4 against a zero-wait slave
        run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 0);
        check("nom_cycles",    32'(cycles), 32'(8 + RD_CYC));
        check("nom_busy1",     32'(busy_at1), 1);
        check("nom_busy_done", 32'(busy_at_done), 0);
        check("nom_done_pulse",32'(done_after), 0);
        check("nom_error",     32'(err_at_done), 0);
        check("nom_aw_n",      32'(aw_count - aw_base), 4);
        check("nom_aw0",       32'(aw_hist[aw_base + 8'd0]), 32'h0);
        check("nom_aw1",       32'(aw_hist[aw_base + 8'd1]), 32'h4);
        check("nom_aw2",       32'(aw_hist[aw_base + 8'd2]), 32'h8);
        check("nom_aw3",       32'(aw_hist[aw_base + 8'd3]), 32'hC);
        check("nom_mem0",      mem[0], 32'd1);
        check("nom_mem1",      mem[1], 32'd2);
        check("nom_mem2",      mem[2], 32'd3);
        check("nom_mem3",      mem[3], 32'd4);
        check("nom_ar_n",      32'(ar_count - ar_base), 32'(NUM_RD));

        // SLVERR on the third write
        err_en   = 1'b1;
        err_addr = 4'h8;
        run_seq({32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011}, 0);
        err_en   = 1'b0;
        check("slv_cycles",    32'(cycles), 6);
        check("slv_error",     32'(err_at_done), 1);
        check("slv_err_idx",   32'(erridx_at_done), 2);
        check("slv_aw_n",      32'(aw_count - aw_base), 3);
        check("slv_aw_last",   32'(aw_hist[aw_base + 8'd2]), 32'h8);
        check("slv_ar_n",      32'(ar_count - ar_base), 0);
        check("slv_done_pulse",32'(done_after), 0);
        check("slv_error_sticky", 32'(error), 1);

`ifdef AXI_TIMER_CFG_READBACK_EN
        // corrupted read-back of register 1
        rd_cor_en   = 1'b1;
        rd_cor_addr = 4'h4;
        run_seq({32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 0);
        rd_cor_en   = 1'b0;
        check("rdc_err_clear", 32'(err_at1), 0);
        check("rdc_cycles",    32'(cycles), 12);
        check("rdc_error",     32'(err_at_done), 1);
        check("rdc_err_idx",   32'(erridx_at_done), 1);
        check("rdc_ar_n",      32'(ar_count - ar_base), 2);
        check("rdc_ar_last",   32'(ar_hist[ar_base + 8'd1]), 32'h4);
`endif

        // AWREADY three cycles late, WREADY immediate
        aw_delay = 3;
        run_seq({32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF}, 0);
        aw_delay = 0;
        check("dly_err_clear", 32'(err_at1), 0);
        check("dly_cycles",    32'(cycles), 32'(20 + RD_CYC));
        check("dly_awv_cyc",   32'(awv_cyc), 16);
        check("dly_wv_cyc",    32'(wv_cyc), 4);
        check("dly_bready",    32'(bready_early), 0);
        check("dly_error",     32'(err_at_done), 0);
        check("dly_mem0",      mem[0], 32'hDEAD_BEEF);
        check("dly_mem1",      mem[1], 32'h1234_5678);
        check("dly_mem2",      mem[2], 32'h0000_0000);
        check("dly_mem3",      mem[3], 32'hFFFF_FFFF);

        // second start pulse while busy, with cfg_data changed behind it
        run_seq({32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}, 3);
        check("ign_cycles",    32'(cycles), 32'(8 + RD_CYC));
        check("ign_aw_n",      32'(aw_count - aw_base), 4);
        check("ign_mem0",      mem[0], 32'hA0A0_0000);
        check("ign_mem3",      mem[3], 32'hA0A0_0003);
        check("ign_error",     32'(err_at_done), 0);
        check("ign_idle_after",32'(busy), 0);

        // asynchronous reset while the first write address is stalled
        aw_delay = 3;
        cfg_data = {32'd8, 32'd7, 32'd6, 32'd5};
        start    = 1'b1;
        @(negedge ACLK);
        start    = 1'b0;
        @(negedge ACLK);
        check("mid_awvalid_pre", 32'(M_AXI_AWVALID), 1);
        check("mid_wvalid_pre",  32'(M_AXI_WVALID), 0);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_awvalid", 32'(M_AXI_AWVALID), 0);
        check("mid_wvalid",  32'(M_AXI_WVALID), 0);
        check("mid_busy",    32'(busy), 0);
        check("mid_bready",  32'(M_AXI_BREADY), 0);
        @(negedge ACLK);
        ARESETN  = 1'b1;
        aw_delay = 0;
        @(negedge ACLK);

        run_seq({32'h0000_0D0D, 32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A}, 0);
        check("rec_cycles", 32'(cycles), 32'(8 + RD_CYC));
        check("rec_error",  32'(err_at_done), 0);
        check("rec_mem1",   mem[1], 32'h0000_0B0B);
        check("rec_mem2",   mem[2], 32'h0000_0C0C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
